// File: rtl/servo_cmd_conditioner.sv
// Pushbutton conditioning (sync, debounce, press, hold-to-autorepeat) and the bounded
// position word that feeds the servo PWM stage. Index 0 is the increment button, 1 decrement.
module servo_cmd_conditioner #(
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned POS_MIN       = 25,
  parameter int unsigned POS_MAX       = 125,
  parameter int unsigned POS_STEP      = 5,
  parameter int unsigned POS_RST       = 25,
  parameter int unsigned POS_W         = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pb_inc,
  input  logic             pb_dec,
  output logic [POS_W-1:0] pos,
  output logic             step_inc,
  output logic             step_dec,
  output logic             at_min,
  output logic             at_max
);

  localparam int unsigned DebW   = $clog2(DEB_CYCLES) + 1;
  localparam int unsigned TmrMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax) + 1;
  localparam int unsigned PosXW  = POS_W + 1;

  localparam logic [DebW-1:0]  DebLast    = DebW'(DEB_CYCLES - 1);
  localparam logic [DebW-1:0]  DebOne     = DebW'(1);
  // Timers load N-1 so the request lands exactly N cycles after the previous one.
  localparam logic [TmrW-1:0]  HoldLoad   = TmrW'(HOLD_CYCLES - 1);
  localparam logic [TmrW-1:0]  RepeatLoad = TmrW'(REPEAT_CYCLES - 1);
  localparam logic [TmrW-1:0]  TmrOne     = TmrW'(1);
  localparam logic [PosXW-1:0] PosMinX    = PosXW'(POS_MIN);
  localparam logic [PosXW-1:0] PosMaxX    = PosXW'(POS_MAX);
  localparam logic [PosXW-1:0] PosStepX   = PosXW'(POS_STEP);
  localparam logic [POS_W-1:0] PosMin     = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] PosMax     = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] PosRst     = POS_W'(POS_RST);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} btn_state_e;

  logic [1:0]       raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       stable_q, stable_d;
  logic [1:0]       fall_q, fall_d;
  logic [1:0]       req_q, req_d;
  logic [DebW-1:0]  deb_cnt_q [2];
  logic [DebW-1:0]  deb_cnt_d [2];
  logic [TmrW-1:0]  tmr_q [2];
  logic [TmrW-1:0]  tmr_d [2];
  btn_state_e       state_q [2];
  btn_state_e       state_d [2];

  logic [POS_W-1:0] pos_q, pos_d;
  logic             step_inc_q, step_inc_d;
  logic             step_dec_q, step_dec_d;
  logic             inc_req, dec_req;
  logic [PosXW-1:0] pos_ext, pos_up, pos_dn;

  assign raw = {pb_dec, pb_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      stable_q   <= 2'b11;
      fall_q     <= 2'b00;
      req_q      <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= '0;
        tmr_q[i]     <= '0;
        state_q[i]   <= StIdle;
      end
      pos_q      <= PosRst;
      step_inc_q <= 1'b0;
      step_dec_q <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      fall_q     <= fall_d;
      req_q      <= req_d;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        tmr_q[i]     <= tmr_d[i];
        state_q[i]   <= state_d[i];
      end
      pos_q      <= pos_d;
      step_inc_q <= step_inc_d;
      step_dec_q <= step_dec_d;
    end
  end

  // Debounce: the level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    fall_d   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DebLast) begin
        deb_cnt_d[i] = '0;
        stable_d[i]  = sync2_q[i];
        fall_d[i]    = ~sync2_q[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DebOne;
      end
    end
  end

  // Press / autorepeat FSM per button; only a fresh debounced 1->0 edge starts a press.
  always_comb begin
    req_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      tmr_d[i]   = tmr_q[i];
      if (!enable) begin
        state_d[i] = StIdle;
        tmr_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          StIdle: begin
            if (fall_q[i]) begin
              state_d[i] = StHold;
              tmr_d[i]   = HoldLoad;
              req_d[i]   = 1'b1;
            end
          end
          StHold, StRepeat: begin
            if (stable_q[i]) begin
              state_d[i] = StIdle;
              tmr_d[i]   = '0;
            end else if (tmr_q[i] == '0) begin
              state_d[i] = StRepeat;
              tmr_d[i]   = RepeatLoad;
              req_d[i]   = 1'b1;
            end else begin
              tmr_d[i] = tmr_q[i] - TmrOne;
            end
          end
          default: begin
            state_d[i] = StIdle;
            tmr_d[i]   = '0;
          end
        endcase
      end
    end
  end

  assign inc_req = req_q[0] & enable;
  assign dec_req = req_q[1] & enable;
  assign pos_ext = {1'b0, pos_q};
  assign pos_up  = pos_ext + PosStepX;
  assign pos_dn  = pos_ext - PosStepX;

  // Simultaneous requests cancel; out-of-range steps are dropped rather than clamped.
  always_comb begin
    pos_d      = pos_q;
    step_inc_d = 1'b0;
    step_dec_d = 1'b0;
    if (inc_req && !dec_req) begin
      if (pos_up <= PosMaxX) begin
        pos_d      = pos_up[POS_W-1:0];
        step_inc_d = 1'b1;
      end
    end else if (dec_req && !inc_req) begin
      if (pos_ext >= PosMinX + PosStepX) begin
        pos_d      = pos_dn[POS_W-1:0];
        step_dec_d = 1'b1;
      end
    end
  end

  assign pos      = pos_q;
  assign step_inc = step_inc_q;
  assign step_dec = step_dec_q;
  assign at_min   = (pos_q == PosMin);
  assign at_max   = (pos_q == PosMax);

endmodule

// File: tb/tb_servo_cmd_conditioner.sv
// Bench for servo_cmd_conditioner: directed scenarios plus randomized buttons/enable,
// with a timing-level reference model of press and autorepeat behaviour.
module tb_servo_cmd_conditioner;

  localparam int DEB   = 4;
  localparam int HOLD  = 20;
  localparam int REP   = 8;
  localparam int PMIN  = 25;
  localparam int PMAX  = 125;
  localparam int PSTEP = 5;
  localparam int PW    = 11;

  logic          clk, rst, enable, pb_inc, pb_dec;
  logic [PW-1:0] pos;
  logic          step_inc, step_dec, at_min, at_max;

  int checks, errors;

  // Reference model state
  int m_pos, m_cyc;
  bit m_inc, m_dec;
  bit m_stable [2];
  bit m_fell   [2];
  bit m_active [2];
  bit m_req    [2];
  int m_next   [2];
  bit hist     [2][DEB+2];

  servo_cmd_conditioner #(
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .POS_MIN      (PMIN),
    .POS_MAX      (PMAX),
    .POS_STEP     (PSTEP),
    .POS_RST      (25),
    .POS_W        (PW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .pb_inc  (pb_inc),
    .pb_dec  (pb_dec),
    .pos     (pos),
    .step_inc(step_inc),
    .step_dec(step_dec),
    .at_min  (at_min),
    .at_max  (at_max)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a level is accepted once the last DEB synchronized samples (raw delayed 2 cycles)
  // all disagree with it; a press requests at once, then after HOLD, then every REP cycles.
  always @(posedge clk or negedge rst) begin : model
    bit r [2];
    bit nreq, all_diff;
    if (!rst) begin
      m_pos = 25; m_inc = 0; m_dec = 0; m_cyc = 0;
      for (int i = 0; i < 2; i++) begin
        m_stable[i] = 1; m_fell[i] = 0; m_active[i] = 0; m_req[i] = 0; m_next[i] = 0;
        for (int j = 0; j < DEB + 2; j++) hist[i][j] = 1;
      end
    end else begin
      r[0] = pb_inc;
      r[1] = pb_dec;
      m_inc = 0;
      m_dec = 0;
      if (enable && m_req[0] && !m_req[1] && (m_pos + PSTEP <= PMAX)) begin
        m_pos = m_pos + PSTEP; m_inc = 1;
      end else if (enable && m_req[1] && !m_req[0] && (m_pos - PSTEP >= PMIN)) begin
        m_pos = m_pos - PSTEP; m_dec = 1;
      end
      for (int i = 0; i < 2; i++) begin
        nreq = 0;
        if (!enable) m_active[i] = 0;
        else if (m_active[i]) begin
          if (m_stable[i]) m_active[i] = 0;
          else if (m_cyc == m_next[i]) begin nreq = 1; m_next[i] = m_cyc + REP; end
        end else if (m_fell[i]) begin
          m_active[i] = 1; nreq = 1; m_next[i] = m_cyc + HOLD;
        end
        m_req[i] = nreq;
      end
      for (int i = 0; i < 2; i++) begin
        for (int j = DEB + 1; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = r[i];
        all_diff = 1;
        for (int j = 2; j < DEB + 2; j++) if (hist[i][j] == m_stable[i]) all_diff = 0;
        m_fell[i] = all_diff && m_stable[i];
        if (all_diff) m_stable[i] = !m_stable[i];
      end
      m_cyc++;
    end
  end

  // Scoreboard: every cycle out of reset, outputs must match the model.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (pos !== PW'(m_pos)) begin
        errors++;
        if (errors < 40) $display("FAIL sb_pos t=%0t got %0d expected %0d", $time, pos, m_pos);
      end
      checks++;
      if (step_inc !== m_inc || step_dec !== m_dec) begin
        errors++;
        if (errors < 40) $display("FAIL sb_step t=%0t got inc=%0b dec=%0b expected inc=%0b dec=%0b",
                                  $time, step_inc, step_dec, m_inc, m_dec);
      end
      checks++;
      if (at_min !== (m_pos == PMIN) || at_max !== (m_pos == PMAX)) begin
        errors++;
        if (errors < 40) $display("FAIL sb_flags t=%0t got min=%0b max=%0b for pos %0d",
                                  $time, at_min, at_max, m_pos);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    pb_inc = 1; pb_dec = 1; enable = 1; rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
  endtask

  // Drive a press of low_len cycles inside a window of total cycles; count step pulses.
  task automatic run_press(input bit lo_inc, input bit lo_dec, input int low_len,
                           input int total, output int n_inc, output int n_dec);
    n_inc = 0; n_dec = 0;
    for (int t = 0; t < total; t++) begin
      @(negedge clk);
      pb_inc = (lo_inc && t < low_len) ? 1'b0 : 1'b1;
      pb_dec = (lo_dec && t < low_len) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (step_inc) n_inc++;
      if (step_dec) n_dec++;
    end
  endtask

  task automatic test_reset();
    #2 rst = 0;
    #1;
    checks++; if (pos !== 11'd25) begin errors++; $display("FAIL reset_pos got %0d expected 25", pos); end
    checks++; if (at_min !== 1'b1) begin errors++; $display("FAIL reset_at_min got %0b expected 1", at_min); end
    checks++; if (at_max !== 1'b0) begin errors++; $display("FAIL reset_at_max got %0b expected 0", at_max); end
    checks++; if (step_inc !== 1'b0 || step_dec !== 1'b0) begin
      errors++; $display("FAIL reset_steps got %0b%0b expected 00", step_inc, step_dec);
    end
    repeat (3) @(negedge clk);
    checks++; if (pos !== 11'd25) begin errors++; $display("FAIL reset_hold_pos got %0d expected 25", pos); end
    #2 rst = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_press();
    int n, nd, t_at;
    n = 0; nd = 0; t_at = -1;
    do_reset();
    @(negedge clk); pb_inc = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (step_inc) begin n++; if (t_at < 0) t_at = t; end
      if (step_dec) nd++;
      if (t == 6) begin
        checks++; if (pos !== 11'd25) begin errors++; $display("FAIL press_early got %0d expected 25", pos); end
      end
      if (t == 7) begin
        checks++; if (pos !== 11'd30) begin errors++; $display("FAIL press_latency got %0d expected 30", pos); end
      end
      if (t == 11) pb_inc = 1;
    end
    checks++; if (n != 1 || nd != 0) begin errors++; $display("FAIL press_pulses got %0d/%0d expected 1/0", n, nd); end
    checks++; if (t_at != 7) begin errors++; $display("FAIL press_time got %0d expected 7", t_at); end
    checks++; if (pos !== 11'd30) begin errors++; $display("FAIL press_final got %0d expected 30", pos); end
  endtask

  task automatic test_bounce();
    int n;
    n = 0;
    do_reset();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (step_inc || step_dec) n++;
      pb_inc = (t < 20 && (t % 4) < 3) ? 1'b0 : 1'b1;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL bounce_pulses got %0d expected 0", n); end
    checks++; if (pos !== 11'd25 || at_min !== 1'b1) begin
      errors++; $display("FAIL bounce_pos got %0d expected 25", pos);
    end
  endtask

  task automatic test_autorepeat();
    int times[$];
    int exp_t [6] = '{7, 27, 35, 43, 51, 59};
    int got;
    do_reset();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      pb_inc = (t < 60) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (step_inc) times.push_back(t);
    end
    checks++; if (times.size() != 6) begin
      errors++; $display("FAIL repeat_count got %0d expected 6", times.size());
    end
    for (int k = 0; k < 6; k++) begin
      got = (k < times.size()) ? times[k] : -1;
      checks++; if (got != exp_t[k]) begin
        errors++; $display("FAIL repeat_time[%0d] got %0d expected %0d", k, got, exp_t[k]);
      end
    end
    checks++; if (pos !== 11'd55) begin errors++; $display("FAIL repeat_pos got %0d expected 55", pos); end
  endtask

  task automatic test_limits();
    int ni, nd;
    do_reset();
    run_press(1, 0, 220, 250, ni, nd);
    checks++; if (ni != 20) begin errors++; $display("FAIL limit_steps got %0d expected 20", ni); end
    checks++; if (pos !== 11'd125 || at_max !== 1'b1 || at_min !== 1'b0) begin
      errors++; $display("FAIL limit_top got %0d max=%0b expected 125 max=1", pos, at_max);
    end
    run_press(1, 0, 12, 40, ni, nd);
    checks++; if (ni != 0 || pos !== 11'd125) begin
      errors++; $display("FAIL limit_inc_at_max got %0d pulses pos %0d expected 0 pulses pos 125", ni, pos);
    end
    run_press(0, 1, 12, 40, ni, nd);
    checks++; if (nd != 1 || pos !== 11'd120 || at_max !== 1'b0) begin
      errors++; $display("FAIL limit_dec got %0d pulses pos %0d expected 1 pulse pos 120", nd, pos);
    end
  endtask

  task automatic test_both_and_enable();
    int ni, nd, n;
    do_reset();
    run_press(1, 1, 12, 40, ni, nd);
    checks++; if (ni != 0 || nd != 0 || pos !== 11'd25) begin
      errors++; $display("FAIL both_pressed got %0d/%0d pos %0d expected 0/0 pos 25", ni, nd, pos);
    end
    n = 0;
    @(negedge clk); enable = 0; pb_inc = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (t == 20) enable = 1;
      @(posedge clk); #1;
      if (step_inc) n++;
    end
    checks++; if (n != 0 || pos !== 11'd25) begin
      errors++; $display("FAIL enable_held got %0d pulses pos %0d expected 0 pulses pos 25", n, pos);
    end
    @(negedge clk); pb_inc = 1;
    repeat (20) @(negedge clk);
    run_press(1, 0, 12, 40, ni, nd);
    checks++; if (ni != 1 || pos !== 11'd30) begin
      errors++; $display("FAIL enable_repress got %0d pulses pos %0d expected 1 pulse pos 30", ni, pos);
    end
  endtask

  task automatic test_rst_autorepeat();
    int n, t_at;
    n = 0; t_at = -1;
    do_reset();
    @(negedge clk); pb_inc = 0;
    repeat (40) begin @(posedge clk); #1; end
    checks++; if (pos !== 11'd40) begin errors++; $display("FAIL rst_pre got %0d expected 40", pos); end
    @(posedge clk); #3 rst = 0; #1;
    checks++; if (pos !== 11'd25 || step_inc !== 1'b0 || at_min !== 1'b1) begin
      errors++; $display("FAIL rst_async got pos %0d step %0b expected 25 0", pos, step_inc);
    end
    @(negedge clk); #2 rst = 1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (step_inc) begin n++; if (t_at < 0) t_at = t; end
    end
    checks++; if (n != 1 || t_at != 7) begin
      errors++; $display("FAIL rst_release got %0d pulses first at %0d expected 1 at 7", n, t_at);
    end
    checks++; if (pos !== 11'd30) begin errors++; $display("FAIL rst_release_pos got %0d expected 30", pos); end
    @(negedge clk); pb_inc = 1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    int rem_i, rem_d;
    rem_i = 0; rem_d = 0;
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (rem_i == 0) begin pb_inc = 1'($urandom_range(0, 1)); rem_i = $urandom_range(1, 60); end
      if (rem_d == 0) begin pb_dec = 1'($urandom_range(0, 1)); rem_d = $urandom_range(1, 60); end
      rem_i--; rem_d--;
      if ($urandom_range(0, 199) == 0) enable = ~enable;
    end
    @(negedge clk); pb_inc = 1; pb_dec = 1; enable = 1;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1; enable = 1; pb_inc = 1; pb_dec = 1;
    test_reset();
    test_single_press();
    test_bounce();
    test_autorepeat();
    test_limits();
    test_both_and_enable();
    test_rst_autorepeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
